// File: rtl/debounce_8way.sv
// 8-channel two-flop synchronizer plus per-channel debounce counter.
// Registered debounced levels with one-cycle rise/fall pulses aligned to the level change.
module debounce_8way #(
    parameter int unsigned N_CYCLES = 20000,
    parameter int unsigned CW       = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic [7:0] out,
    output logic [7:0] rise,
    output logic [7:0] fall
);

    localparam logic [CW-1:0] TermCnt = CW'(N_CYCLES - 1);

    logic [7:0]    s1_q, s1_d;
    logic [7:0]    s2_q, s2_d;
    logic [7:0]    out_q, out_d;
    logic [7:0]    rise_q, rise_d;
    logic [7:0]    fall_q, fall_d;
    logic [CW-1:0] cnt_q [8];
    logic [CW-1:0] cnt_d [8];

    always_comb begin
        s1_d   = in;
        s2_d   = s1_q;
        out_d  = out_q;
        rise_d = 8'h00;
        fall_d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != out_q[i]) begin
                // Terminal count commits the new level; any agreeing cycle restarts the count.
                if (cnt_q[i] == TermCnt) begin
                    out_d[i]  = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 8'h00;
            s2_q   <= 8'h00;
            out_q  <= 8'h00;
            rise_q <= 8'h00;
            fall_q <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_debounce_8way.sv
// Directed bench for debounce_8way: one instance with N_CYCLES=4, one with N_CYCLES=1.
module tb_debounce_8way;

    logic       clk;
    logic       reset;
    logic [7:0] in4, out4, rise4, fall4;
    logic [7:0] in1, out1, rise1, fall1;

    int checks = 0;
    int errors = 0;

    debounce_8way #(.N_CYCLES(4), .CW(3)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .in    (in4),
        .out   (out4),
        .rise  (rise4),
        .fall  (fall4)
    );

    debounce_8way #(.N_CYCLES(1), .CW(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .in    (in1),
        .out   (out1),
        .rise  (rise1),
        .fall  (fall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    logic [7:0] m_s1, m_s2, m_out, m_prev, r;
    int         nrise, nfall;

    initial begin
        reset = 1'b1;
        in4   = 8'hFF;
        in1   = 8'h00;

        // 1: reset held with inputs high, then release
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t1_rst_out", out4, 8'h00);
            chk("t1_rst_rise", rise4, 8'h00);
            chk("t1_rst_fall", fall4, 8'h00);
        end
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("t1_wait_out", out4, 8'h00);
            chk("t1_wait_rise", rise4, 8'h00);
        end
        tick();
        chk("t1_e6_out", out4, 8'hFF);
        chk("t1_e6_rise", rise4, 8'hFF);
        chk("t1_e6_fall", fall4, 8'h00);
        tick();
        chk("t1_e7_out", out4, 8'hFF);
        chk("t1_e7_rise", rise4, 8'h00);

        // 4: release all from settled 8'hFF
        in4 = 8'h00;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("t4_wait_out", out4, 8'hFF);
            chk("t4_wait_fall", fall4, 8'h00);
        end
        tick();
        chk("t4_e6_out", out4, 8'h00);
        chk("t4_e6_fall", fall4, 8'hFF);
        chk("t4_e6_rise", rise4, 8'h00);
        tick();
        chk("t4_e7_fall", fall4, 8'h00);

        // 2: bounce on channel 0, final 0->1 before relative edge 6
        nrise = 0;
        nfall = 0;
        r = 8'b0010_1101;
        for (int e = 1; e <= 14; e++) begin
            in4 = (e <= 6) ? {7'b0, r[e-1]} : 8'h01;
            tick();
            if (rise4[0]) nrise++;
            if (fall4[0]) nfall++;
            if (e <= 10) chk("t2_hold_out", out4, 8'h00);
            if (e == 11) chk("t2_e11_out", out4, 8'h01);
            if (e == 11) chk("t2_e11_rise", rise4, 8'h01);
            if (e == 12) chk("t2_e12_rise", rise4, 8'h00);
        end
        chk("t2_rise_count", 8'(nrise), 8'd1);
        chk("t2_fall_count", 8'(nfall), 8'd0);

        // 3: independent channels
        in4 = 8'h00;
        pulse_reset();
        tick();
        in4 = 8'h01;
        tick();
        tick();
        in4 = 8'h81;
        tick();
        tick();
        tick();
        chk("t3_e5_out", out4, 8'h00);
        tick();
        chk("t3_e6_out", out4, 8'h01);
        chk("t3_e6_rise", rise4, 8'h01);
        tick();
        chk("t3_e7_out", out4, 8'h01);
        chk("t3_e7_rise", rise4, 8'h00);
        tick();
        chk("t3_e8_out", out4, 8'h81);
        chk("t3_e8_rise", rise4, 8'h80);
        tick();
        chk("t3_e9_rise", rise4, 8'h00);

        // 5: reset mid-count discards the partial count
        in4 = 8'h00;
        pulse_reset();
        tick();
        in4 = 8'h04;
        for (int e = 1; e <= 4; e++) tick();
        chk("t5_e4_out", out4, 8'h00);
        reset = 1'b1;
        for (int e = 0; e < 2; e++) begin
            tick();
            chk("t5_rst_out", out4, 8'h00);
            chk("t5_rst_rise", rise4, 8'h00);
        end
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        chk("t5_e5_out", out4, 8'h00);
        tick();
        chk("t5_e6_out", out4, 8'h04);
        chk("t5_e6_rise", rise4, 8'h04);

        // 6: N_CYCLES = 1
        in4 = 8'h00;
        pulse_reset();
        tick();
        in1 = 8'hA5;
        tick();
        tick();
        chk("t6_e2_out", out1, 8'h00);
        tick();
        chk("t6_e3_out", out1, 8'hA5);
        chk("t6_e3_rise", rise1, 8'hA5);
        tick();
        chk("t6_e4_rise", rise1, 8'h00);
        m_s1  = 8'hA5;
        m_s2  = 8'hA5;
        m_out = 8'hA5;
        for (int k = 0; k < 40; k++) begin
            in1    = 8'($urandom);
            m_prev = m_out;
            m_out  = m_s2;
            m_s2   = m_s1;
            m_s1   = in1;
            tick();
            chk("t6_rand_out", out1, m_out);
            chk("t6_rand_rise", rise1, m_out & ~m_prev);
            chk("t6_rand_fall", fall1, ~m_out & m_prev);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
